alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver_pkg.sv | 33 +++
 rtl/alu_driver_if.sv | 48 ++++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_driver.sv | 138 +++++++++++++
 tb/tb_alu_driver.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_driver_pkg.sv
// Shared definitions for the ALU driver: opcode constants, command field
// positions, FSM state encoding and a small command-decode helper.
package alu_driver_pkg;

  localparam int DEF_NUMBITS  = 16;
  localparam int DEF_NUMREGS  = 8;
  localparam int CMD_LOAD_BIT = 3;

  // ALU opcodes as understood by the attached ALU.
  typedef enum logic [2:0] {
    OP_UADD = 3'b000,
    OP_SADD = 3'b001,
    OP_USUB = 3'b010,
    OP_SSUB = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SHR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // A command with the load bit set writes its immediate instead of using the ALU.
  function automatic logic is_load(input logic [3:0] op);
    return op[CMD_LOAD_BIT];
  endfunction

endpackage

// File: rtl/alu_driver_if.sv
// Bus bundle between the command source / ALU side and the driver.
// The slave modport is the driver's view; master is the environment's view.
interface alu_driver_if #(
  parameter int NUMBITS = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic [2:0]         cmd_rd;
  logic [2:0]         cmd_rs1;
  logic [2:0]         cmd_rs2;
  logic [NUMBITS-1:0] cmd_imm;

  logic [NUMBITS-1:0] alu_A;
  logic [NUMBITS-1:0] alu_B;
  logic [2:0]         alu_opcode;
  logic [NUMBITS-1:0] alu_result;
  logic               alu_carryout;
  logic               alu_overflow;
  logic               alu_zero;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [NUMBITS-1:0] rsp_data;
  logic               rsp_carry;
  logic               rsp_overflow;
  logic               rsp_zero;

  logic               ovf_sticky;
  logic               ovf_clear;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  alu_result, alu_carryout, alu_overflow, alu_zero,
    input  rsp_ready, ovf_clear,
    output cmd_ready, alu_A, alu_B, alu_opcode,
    output rsp_valid, rsp_data, rsp_carry, rsp_overflow, rsp_zero, ovf_sticky
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output alu_result, alu_carryout, alu_overflow, alu_zero,
    output rsp_ready, ovf_clear,
    input  cmd_ready, alu_A, alu_B, alu_opcode,
    input  rsp_valid, rsp_data, rsp_carry, rsp_overflow, rsp_zero, ovf_sticky
  );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// every entry cleared by synchronous reset.
module alu_regfile #(
  parameter  int NUMBITS = 16,
  parameter  int NUMREGS = 8,
  localparam int AW      = $clog2(NUMREGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [NUMBITS-1:0] wdata,
  input  logic [AW-1:0]      raddr1,
  output logic [NUMBITS-1:0] rdata1,
  input  logic [AW-1:0]      raddr2,
  output logic [NUMBITS-1:0] rdata2
);

  logic [NUMBITS-1:0] entries [NUMREGS];

  generate
    for (genvar gi = 0; gi < NUMREGS; gi++) begin : g_entry
      logic [NUMBITS-1:0] q_reg;

      // Entry clears on reset and loads when the write port addresses it.
      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign entries[gi] = q_reg;
    end
  endgenerate

  assign rdata1 = entries[raddr1];
  assign rdata2 = entries[raddr2];

endmodule

// File: rtl/alu_driver.sv
// Sequences one command at a time onto an external registered ALU:
// operands out, wait for the ALU's one-cycle result, write back, respond.
// Load-immediate commands bypass the ALU and respond on the next cycle.
module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int NUMBITS = DEF_NUMBITS,
  parameter int NUMREGS = DEF_NUMREGS
) (
  input logic       clk,
  input logic       reset,
  alu_driver_if.slave bus
);

  state_e             state_reg;
  logic [2:0]         rd_reg;
  logic [NUMBITS-1:0] alu_a_reg;
  logic [NUMBITS-1:0] alu_b_reg;
  logic [2:0]         alu_opcode_reg;
  logic               rsp_valid_reg;
  logic [NUMBITS-1:0] rsp_data_reg;
  logic               rsp_carry_reg;
  logic               rsp_overflow_reg;
  logic               rsp_zero_reg;
  logic               ovf_sticky_reg;

  logic               accept;
  logic               accept_load;
  logic               rf_we;
  logic [2:0]         rf_waddr;
  logic [NUMBITS-1:0] rf_wdata;
  logic [NUMBITS-1:0] rf_rdata1;
  logic [NUMBITS-1:0] rf_rdata2;

  assign accept      = (state_reg == ST_IDLE) && bus.cmd_valid;
  assign accept_load = accept && is_load(bus.cmd_op);

  // The only two write sources: ALU result in CAPTURE, immediate at load accept.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.cmd_rd;
    rf_wdata = bus.cmd_imm;
    if (state_reg == ST_CAPTURE) begin
      rf_we    = 1'b1;
      rf_waddr = rd_reg;
      rf_wdata = bus.alu_result;
    end else if (accept_load) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile #(
    .NUMBITS(NUMBITS),
    .NUMREGS(NUMREGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr1(bus.cmd_rs1),
    .rdata1(rf_rdata1),
    .raddr2(bus.cmd_rs2),
    .rdata2(rf_rdata2)
  );

  // Command sequencer with registered operand, response and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      rd_reg           <= '0;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      alu_opcode_reg   <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_data_reg     <= '0;
      rsp_carry_reg    <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      rsp_zero_reg     <= 1'b0;
      ovf_sticky_reg   <= 1'b0;
    end else begin
      // A new overflow outranks a clear arriving in the same cycle.
      if ((state_reg == ST_CAPTURE) && bus.alu_overflow) begin
        ovf_sticky_reg <= 1'b1;
      end else if (bus.ovf_clear) begin
        ovf_sticky_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (accept_load) begin
            rsp_data_reg     <= bus.cmd_imm;
            rsp_carry_reg    <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            rsp_zero_reg     <= 1'b0;
            rsp_valid_reg    <= 1'b1;
            state_reg        <= ST_RESP;
          end else if (accept) begin
            alu_a_reg      <= rf_rdata1;
            alu_b_reg      <= rf_rdata2;
            alu_opcode_reg <= bus.cmd_op[2:0];
            rd_reg         <= bus.cmd_rd;
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_data_reg     <= bus.alu_result;
          rsp_carry_reg    <= bus.alu_carryout;
          rsp_overflow_reg <= bus.alu_overflow;
          rsp_zero_reg     <= bus.alu_zero;
          rsp_valid_reg    <= 1'b1;
          state_reg        <= ST_RESP;
        end
        default: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready    = (state_reg == ST_IDLE);
  assign bus.alu_A        = alu_a_reg;
  assign bus.alu_B        = alu_b_reg;
  assign bus.alu_opcode   = alu_opcode_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_data     = rsp_data_reg;
  assign bus.rsp_carry    = rsp_carry_reg;
  assign bus.rsp_overflow = rsp_overflow_reg;
  assign bus.rsp_zero     = rsp_zero_reg;
  assign bus.ovf_sticky   = ovf_sticky_reg;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: plays the command source, the registered ALU and the
// response sink; a transaction-level model predicts every observable output.
module tb_alu_driver;
  import alu_driver_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_driver_if #(.NUMBITS(W)) bus ();

  alu_driver #(.NUMBITS(W), .NUMREGS(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  // Arithmetic of the attached ALU, written from the opcode table.
  function automatic void alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic o, output logic z);
    logic [W:0] s;
    r = '0; c = 1'b0; o = 1'b0;
    case (op)
      OP_UADD: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      OP_SADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_USUB: begin r = a - b; c = (a < b); end
      OP_SSUB: begin
        r = a - b; c = (a < b);
        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a >> b[3:0];
    endcase
    z = (r == '0);
  endfunction

  // ALU environment: one-cycle registered result from the driver's operands.
  logic [W-1:0] nx_r;
  logic nx_c, nx_o, nx_z;
  always_comb begin
    nx_r = '0; nx_c = 1'b0; nx_o = 1'b0; nx_z = 1'b0;
    alu_fn(bus.alu_opcode, bus.alu_A, bus.alu_B, nx_r, nx_c, nx_o, nx_z);
  end
  always @(posedge clk) begin
    bus.alu_result   <= nx_r;
    bus.alu_carryout <= nx_c;
    bus.alu_overflow <= nx_o;
    bus.alu_zero     <= nx_z;
  end

  // ---------------- transaction model ----------------
  logic [W-1:0] m_regs [8];
  bit           started = 0;
  bit           out = 0;
  int           edge_cnt = 0;
  int           acc_edge = 0;
  int           lat = 1;
  bit           e_alu = 0;
  logic [2:0]   e_rd, e_op;
  logic [W-1:0] e_a, e_b, e_d;
  logic         e_c, e_o, e_z;
  bit           m_sticky = 0;

  // Model update on each rising edge from the bench-driven inputs only.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        out = 0;
        m_sticky = 0;
        started = 1;
      end else if (started) begin
        if (out && e_alu && (edge_cnt == acc_edge + 2)) m_regs[e_rd] = e_d;
        if (out && e_alu && (edge_cnt == acc_edge + 2) && e_o) m_sticky = 1;
        else if (bus.ovf_clear) m_sticky = 0;
        if (out) begin
          if (((edge_cnt - 1) >= acc_edge + lat - 1) && bus.rsp_ready) out = 0;
        end else if (bus.cmd_valid) begin
          out = 1;
          acc_edge = edge_cnt;
          e_rd = bus.cmd_rd;
          if (bus.cmd_op[3]) begin
            e_alu = 0; lat = 1;
            e_d = bus.cmd_imm; e_c = 0; e_o = 0; e_z = 0;
            m_regs[bus.cmd_rd] = bus.cmd_imm;
          end else begin
            e_alu = 1; lat = 3;
            e_op = bus.cmd_op[2:0];
            e_a = m_regs[bus.cmd_rs1];
            e_b = m_regs[bus.cmd_rs2];
            alu_fn(e_op, e_a, e_b, e_d, e_c, e_o, e_z);
          end
        end
      end
    end
  end

  // Compare process: every falling edge once reset has been seen.
  initial begin
    bit exp_valid;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_valid = out && (edge_cnt >= acc_edge + lat - 1);
        chk("cmd_ready", bus.cmd_ready, !out);
        chk("rsp_valid", bus.rsp_valid, exp_valid);
        if (exp_valid) begin
          chk("rsp_data", bus.rsp_data, e_d);
          chk("rsp_carry", bus.rsp_carry, e_c);
          chk("rsp_overflow", bus.rsp_overflow, e_o);
          chk("rsp_zero", bus.rsp_zero, e_z);
        end
        if (out && e_alu && (edge_cnt >= acc_edge) && (edge_cnt <= acc_edge + 1)) begin
          chk("alu_A", bus.alu_A, e_a);
          chk("alu_B", bus.alu_B, e_b);
          chk("alu_opcode", bus.alu_opcode, e_op);
        end
        chk("ovf_sticky", bus.ovf_sticky, m_sticky);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [W-1:0] imm);
    int n = 0;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("issue_wait");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic [W-1:0] d, output logic c, output logic o,
                          output logic z, output int latency);
    int n = 0;
    d = '0; c = 0; o = 0; z = 0; latency = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      fail_now("rsp_wait");
      return;
    end
    latency = n + 1;
    d = bus.rsp_data; c = bus.rsp_carry; o = bus.rsp_overflow; z = bus.rsp_zero;
    for (int h = 0; h < hold; h++) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    $display("txn t=%0t rsp_data=%h carry=%b ovf=%b zero=%b latency=%0d hold=%0d",
             $time, d, c, o, z, latency, hold);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] d;
    logic c, o, z;
    int lt;
    logic [3:0] rop;
    logic [W-1:0] rimm;

    reset = 1'b1;
    bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.cmd_imm = '0; bus.rsp_ready = 0; bus.ovf_clear = 0;
    repeat (3) @(negedge clk);
    chk("reset_alu_A", bus.alu_A, 0);
    chk("reset_alu_B", bus.alu_B, 0);
    chk("reset_alu_opcode", bus.alu_opcode, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_flags", {bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero}, 0);
    chk("reset_sticky", bus.ovf_sticky, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    reset = 1'b0;

    // Load immediates: response one cycle after accept, flags clear.
    issue(4'b1000, 3'd1, 3'd0, 3'd0, 16'h0005);
    wait_rsp(0, d, c, o, z, lt);
    chk("loadi_r1_data", d, 16'h0005);
    chk("loadi_r1_flags", {c, o, z}, 0);
    chk("loadi_latency", lt, 1);
    issue(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0003);
    wait_rsp(0, d, c, o, z, lt);
    chk("loadi_r2_data", d, 16'h0003);

    // Unsigned add wrapping to zero.
    issue(4'b1000, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    wait_rsp(0, d, c, o, z, lt);
    issue(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0001);
    wait_rsp(0, d, c, o, z, lt);
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 16'h0000);
    wait_rsp(0, d, c, o, z, lt);
    chk("uadd_data", d, 16'h0000);
    chk("uadd_carry", c, 1);
    chk("uadd_zero", z, 1);
    chk("uadd_latency", lt, 3);
    issue(4'b0101, 3'd4, 3'd3, 3'd3, 16'h0000);
    wait_rsp(0, d, c, o, z, lt);
    chk("r3_written_zero", d, 16'h0000);

    // Signed add overflow and the sticky bit.
    issue(4'b1000, 3'd1, 3'd0, 3'd0, 16'h7FFF);
    wait_rsp(0, d, c, o, z, lt);
    issue(4'b0001, 3'd4, 3'd1, 3'd2, 16'h0000);
    wait_rsp(0, d, c, o, z, lt);
    chk("sadd_data", d, 16'h8000);
    chk("sadd_overflow", o, 1);
    chk("sticky_set", bus.ovf_sticky, 1);
    repeat (3) @(negedge clk);
    chk("sticky_holds", bus.ovf_sticky, 1);
    bus.ovf_clear = 1'b1;
    @(negedge clk);
    bus.ovf_clear = 1'b0;
    chk("sticky_cleared", bus.ovf_sticky, 0);

    // Response back-pressure with a second command waiting.
    issue(4'b1000, 3'd5, 3'd0, 3'd0, 16'h1234);
    bus.cmd_op = 4'b1000; bus.cmd_rd = 3'd6; bus.cmd_imm = 16'h5678;
    bus.cmd_valid = 1'b1;
    wait_rsp(5, d, c, o, z, lt);
    chk("bp_first_data", d, 16'h1234);
    chk("bp_ready_after", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_rsp(0, d, c, o, z, lt);
    chk("bp_second_data", d, 16'h5678);

    // AND with rd == rs1, then reset during ISSUE of the next op.
    issue(4'b1000, 3'd1, 3'd0, 3'd0, 16'h00F0);
    wait_rsp(0, d, c, o, z, lt);
    issue(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0FF0);
    wait_rsp(0, d, c, o, z, lt);
    issue(4'b0100, 3'd1, 3'd1, 3'd2, 16'h0000);
    wait_rsp(0, d, c, o, z, lt);
    chk("and_data", d, 16'h00F0);
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 16'h0000);
    pulse_reset();
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", bus.rsp_valid, 0);
    for (int i = 0; i < 8; i++) begin
      issue(4'b0101, 3'(i), 3'(i), 3'(i), 16'h0000);
      wait_rsp(0, d, c, o, z, lt);
      chk("reg_zero_after_reset", d, 16'h0000);
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      rop = ($urandom_range(0, 2) == 0) ? 4'b1000 : {1'b0, 3'($urandom_range(0, 7))};
      case ($urandom_range(0, 7))
        0: rimm = 16'h7FFF;
        1: rimm = 16'h8000;
        2: rimm = 16'hFFFF;
        3: rimm = 16'h0000;
        default: rimm = 16'($urandom);
      endcase
      bus.ovf_clear = ($urandom_range(0, 3) == 0);
      issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rimm);
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset();
      end else begin
        wait_rsp($urandom_range(0, 3), d, c, o, z, lt);
      end
      bus.ovf_clear = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
